// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared bus header: widths, owner encodings, polarities, rotation helper
package bus_arbiter_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;
    localparam int BUS_OWNER_W = 2;

    typedef enum logic [BUS_OWNER_W-1:0] {
        BUS_OWNER_MASTER_0 = 2'd0,
        BUS_OWNER_MASTER_1 = 2'd1,
        BUS_OWNER_MASTER_2 = 2'd2,
        BUS_OWNER_MASTER_3 = 2'd3
    } bus_owner_e;

    // Active-low control polarity used by req_, grnt_ and as_
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Reset is sensed on the falling edge of an active-low line
    localparam logic RESET_EDGE   = 1'b0;
    localparam logic RESET_ENABLE = 1'b0;

    localparam logic [7:0] BUS_ARB_TIMEOUT_MAX = 8'd255;

    // First requester after cur in rotation order (cur+1, cur+2, cur+3); cur itself
    // is examined last by never being examined, so the releasing master ranks lowest.
    // Returns cur when nobody else requests.
    function automatic bus_owner_e next_owner(input bus_owner_e cur, input logic [3:0] req_n);
        bus_owner_e nxt;
        logic       found;
        logic [1:0] idx;
        nxt   = cur;
        found = 1'b0;
        for (int i = 1; i < 4; i++) begin
            idx = cur + 2'(i);
            if (!found && req_n[idx] == ENABLE_) begin
                nxt   = bus_owner_e'(idx);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bus_master_mux.sv
// rtl/bus_master_mux.sv - combinational 4:1 mux of master bus signals selected by owner
module bus_master_mux
    import bus_arbiter_pkg::*;
(
    input  bus_owner_e              owner,
    input  logic [WORD_ADDR_W-1:0]  m0_addr,
    input  logic [WORD_ADDR_W-1:0]  m1_addr,
    input  logic [WORD_ADDR_W-1:0]  m2_addr,
    input  logic [WORD_ADDR_W-1:0]  m3_addr,
    input  logic                    m0_as_,
    input  logic                    m1_as_,
    input  logic                    m2_as_,
    input  logic                    m3_as_,
    input  logic                    m0_rw,
    input  logic                    m1_rw,
    input  logic                    m2_rw,
    input  logic                    m3_rw,
    input  logic [WORD_DATA_W-1:0]  m0_wr_data,
    input  logic [WORD_DATA_W-1:0]  m1_wr_data,
    input  logic [WORD_DATA_W-1:0]  m2_wr_data,
    input  logic [WORD_DATA_W-1:0]  m3_wr_data,
    output logic [WORD_ADDR_W-1:0]  s_addr,
    output logic                    s_as_,
    output logic                    s_rw,
    output logic [WORD_DATA_W-1:0]  s_wr_data
);

    // Only the owner reaches the slaves; strobes from other masters are dropped here
    always_comb begin
        s_addr    = m0_addr;
        s_as_     = m0_as_;
        s_rw      = m0_rw;
        s_wr_data = m0_wr_data;
        case (owner)
            BUS_OWNER_MASTER_1: begin
                s_addr    = m1_addr;
                s_as_     = m1_as_;
                s_rw      = m1_rw;
                s_wr_data = m1_wr_data;
            end
            BUS_OWNER_MASTER_2: begin
                s_addr    = m2_addr;
                s_as_     = m2_as_;
                s_rw      = m2_rw;
                s_wr_data = m2_wr_data;
            end
            BUS_OWNER_MASTER_3: begin
                s_addr    = m3_addr;
                s_as_     = m3_as_;
                s_rw      = m3_rw;
                s_wr_data = m3_wr_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - 4-master round-robin bus arbiter with owner mux; optional BUS_ARB_TIMEOUT_EN hold timeout
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m0_req_,
    input  logic                    m1_req_,
    input  logic                    m2_req_,
    input  logic                    m3_req_,
    input  logic [WORD_ADDR_W-1:0]  m0_addr,
    input  logic [WORD_ADDR_W-1:0]  m1_addr,
    input  logic [WORD_ADDR_W-1:0]  m2_addr,
    input  logic [WORD_ADDR_W-1:0]  m3_addr,
    input  logic                    m0_as_,
    input  logic                    m1_as_,
    input  logic                    m2_as_,
    input  logic                    m3_as_,
    input  logic                    m0_rw,
    input  logic                    m1_rw,
    input  logic                    m2_rw,
    input  logic                    m3_rw,
    input  logic [WORD_DATA_W-1:0]  m0_wr_data,
    input  logic [WORD_DATA_W-1:0]  m1_wr_data,
    input  logic [WORD_DATA_W-1:0]  m2_wr_data,
    input  logic [WORD_DATA_W-1:0]  m3_wr_data,
    output logic                    m0_grnt_,
    output logic                    m1_grnt_,
    output logic                    m2_grnt_,
    output logic                    m3_grnt_,
    output logic [WORD_ADDR_W-1:0]  s_addr,
    output logic                    s_as_,
    output logic                    s_rw,
    output logic [WORD_DATA_W-1:0]  s_wr_data,
    output logic                    arb_timeout
);

    logic [3:0] req_n;
    bus_owner_e owner_q, owner_d, rotate_owner;

    assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    // Owner keeps the bus while it requests; on release (or hold timeout) rotate
    always_comb begin
        rotate_owner = next_owner(owner_q, req_n);
        owner_d      = owner_q;
        hold_cnt_d   = '0;
        timeout_d    = timeout_q;
        if (req_n[owner_q] != ENABLE_) begin
            owner_d = rotate_owner;
        end else if (rotate_owner != owner_q) begin
            // Owner still holding while someone else waits: count, then force a handover
            if (hold_cnt_q == BUS_ARB_TIMEOUT_MAX) begin
                owner_d   = rotate_owner;
                timeout_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end
    end

    // Hold counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ENABLE) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign arb_timeout = timeout_q;
`else
    // Owner keeps the bus while it requests; on release rotate to the next requester
    always_comb begin
        rotate_owner = next_owner(owner_q, req_n);
        owner_d      = owner_q;
        if (req_n[owner_q] != ENABLE_) begin
            owner_d = rotate_owner;
        end
    end

    assign arb_timeout = 1'b0;
`endif

    // Owner register; reset parks the bus on master 0
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ENABLE) begin
            owner_q <= BUS_OWNER_MASTER_0;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Grants decode the owner register only, so exactly one is low at all times
    assign m0_grnt_ = (owner_q == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
    assign m1_grnt_ = (owner_q == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
    assign m2_grnt_ = (owner_q == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
    assign m3_grnt_ = (owner_q == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;

    bus_master_mux u_mux (
        .owner      (owner_q),
        .m0_addr    (m0_addr),
        .m1_addr    (m1_addr),
        .m2_addr    (m2_addr),
        .m3_addr    (m3_addr),
        .m0_as_     (m0_as_),
        .m1_as_     (m1_as_),
        .m2_as_     (m2_as_),
        .m3_as_     (m3_as_),
        .m0_rw      (m0_rw),
        .m1_rw      (m1_rw),
        .m2_rw      (m2_rw),
        .m3_rw      (m3_rw),
        .m0_wr_data (m0_wr_data),
        .m1_wr_data (m1_wr_data),
        .m2_wr_data (m2_wr_data),
        .m3_wr_data (m3_wr_data),
        .s_addr     (s_addr),
        .s_as_      (s_as_),
        .s_rw       (s_rw),
        .s_wr_data  (s_wr_data)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter (owner rotation, muxing, parking, timeout)
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_n;
    logic [3:0]  as_n;
    logic [3:0]  rw;
    logic [29:0] addr [4];
    logic [31:0] wd   [4];
    logic        m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [29:0] s_addr;
    logic        s_as_, s_rw;
    logic [31:0] s_wr_data;
    logic        arb_timeout;
    logic [3:0]  grnt;

    int checks = 0;
    int passed = 0;
    logic [1:0] exp_q [$];

    always #5 clk = ~clk;

    assign grnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
        .m0_addr(addr[0]), .m1_addr(addr[1]), .m2_addr(addr[2]), .m3_addr(addr[3]),
        .m0_as_(as_n[0]), .m1_as_(as_n[1]), .m2_as_(as_n[2]), .m3_as_(as_n[3]),
        .m0_rw(rw[0]), .m1_rw(rw[1]), .m2_rw(rw[2]), .m3_rw(rw[3]),
        .m0_wr_data(wd[0]), .m1_wr_data(wd[1]), .m2_wr_data(wd[2]), .m3_wr_data(wd[3]),
        .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
        .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .arb_timeout(arb_timeout)
    );

    function automatic logic [3:0] onehot_low(input logic [1:0] o);
        return ~(4'b0001 << o);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b0;
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [1:0] e;
        reset = 1'b0;
        req_n = 4'hF;
        as_n  = 4'hF;
        tick();
        tick();
        checks++; if (grnt !== 4'b1110) $display("FAIL reset_grant got=%b exp=%b", grnt, 4'b1110); else passed++;
        checks++; if (s_addr !== addr[0]) $display("FAIL reset_s_addr got=%h exp=%h", s_addr, addr[0]); else passed++;
        checks++; if (arb_timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", arb_timeout); else passed++;
        reset = 1'b1;
        for (int t = 0; t < 20; t++) begin
            exp_q.push_back(2'd0);
            tick();
            e = exp_q.pop_front();
            checks++; if (grnt !== onehot_low(e)) $display("FAIL idle_park t=%0d got=%b exp=%b", t, grnt, onehot_low(e)); else passed++;
        end
    endtask

    task automatic test_handover();
        logic [1:0] e;
        for (int t = 0; t < 14; t++) begin
            req_n = 4'hF;
            if (t < 10) req_n[0] = 1'b0;
            if (t >= 5 && t < 13) req_n[2] = 1'b0;
            exp_q.push_back((t >= 10) ? 2'd2 : 2'd0);
            tick();
            e = exp_q.pop_front();
            checks++; if (grnt !== onehot_low(e)) $display("FAIL handover_grant t=%0d got=%b exp=%b", t, grnt, onehot_low(e)); else passed++;
            checks++; if (s_addr !== addr[e] || s_rw !== rw[e] || s_wr_data !== wd[e])
                $display("FAIL handover_mux t=%0d got=%h/%b/%h exp=%h/%b/%h", t, s_addr, s_rw, s_wr_data, addr[e], rw[e], wd[e]);
            else passed++;
        end
        checks++; if (s_addr !== 30'h1000_0004) $display("FAIL handover_m2_addr got=%h exp=%h", s_addr, 30'h1000_0004); else passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0] e;
        logic [1:0] o;
        // Asynchronous reset while master 2 owns the bus must return ownership to 0 at once
        #2 reset = 1'b0;
        #1;
        checks++; if (grnt !== 4'b1110) $display("FAIL async_reset_grant got=%b exp=%b", grnt, 4'b1110); else passed++;
        #2 reset = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            o = 2'(k);
            for (int c = 0; c < 4; c++) begin
                req_n = 4'h0;
                if (c == 3) req_n[o] = 1'b1;
                exp_q.push_back((c == 3) ? 2'(o + 2'd1) : o);
                tick();
                e = exp_q.pop_front();
                checks++; if (grnt !== onehot_low(e)) $display("FAIL rr_grant k=%0d c=%0d got=%b exp=%b", k, c, grnt, onehot_low(e)); else passed++;
            end
        end
    endtask

    task automatic test_skip();
        logic [1:0] e;
        logic [3:0] pat [2];
        logic [1:0] exo [2];
        pat[0] = 4'b1101; exo[0] = 2'd1;
        pat[1] = 4'b0110; exo[1] = 2'd3;
        for (int i = 0; i < 2; i++) begin
            req_n = pat[i];
            exp_q.push_back(exo[i]);
            tick();
            e = exp_q.pop_front();
            checks++; if (grnt !== onehot_low(e)) $display("FAIL skip_grant i=%0d got=%b exp=%b", i, grnt, onehot_low(e)); else passed++;
        end
    endtask

    task automatic test_strobe_block();
        logic [1:0] e;
        req_n = 4'b1110;
        exp_q.push_back(2'd0);
        tick();
        e = exp_q.pop_front();
        checks++; if (grnt !== onehot_low(e)) $display("FAIL strobe_setup got=%b exp=%b", grnt, onehot_low(e)); else passed++;
        for (int t = 0; t < 6; t++) begin
            req_n = 4'b1100;
            as_n  = 4'hF;
            as_n[1] = 1'b0;
            as_n[0] = t[0];
            exp_q.push_back(2'd0);
            tick();
            e = exp_q.pop_front();
            checks++; if (grnt !== onehot_low(e)) $display("FAIL strobe_block_grant t=%0d got=%b exp=%b", t, grnt, onehot_low(e)); else passed++;
            checks++; if (s_as_ !== as_n[0]) $display("FAIL strobe_follow_m0 t=%0d got=%b exp=%b", t, s_as_, as_n[0]); else passed++;
        end
        req_n = 4'b1101;
        exp_q.push_back(2'd1);
        tick();
        e = exp_q.pop_front();
        checks++; if (grnt !== onehot_low(e)) $display("FAIL strobe_release_grant got=%b exp=%b", grnt, onehot_low(e)); else passed++;
        checks++; if (s_as_ !== 1'b0) $display("FAIL strobe_m1_as got=%b exp=0", s_as_); else passed++;
        as_n = 4'hF;
    endtask

    task automatic test_parking();
        logic [1:0] e;
        for (int t = 0; t < 3; t++) begin
            req_n = 4'hF;
            exp_q.push_back(2'd1);
            tick();
            e = exp_q.pop_front();
            checks++; if (grnt !== onehot_low(e)) $display("FAIL park_grant t=%0d got=%b exp=%b", t, grnt, onehot_low(e)); else passed++;
        end
        req_n = 4'b1101;
        #1;
        checks++; if (m1_grnt_ !== 1'b0) $display("FAIL park_zero_latency got=%b exp=0", m1_grnt_); else passed++;
        exp_q.push_back(2'd1);
        tick();
        e = exp_q.pop_front();
        checks++; if (grnt !== onehot_low(e)) $display("FAIL park_hold got=%b exp=%b", grnt, onehot_low(e)); else passed++;
    endtask

    task automatic test_reassert();
        logic [1:0] e;
        logic [3:0] pat [4];
        logic [1:0] exo [4];
        pat[0] = 4'b1001; exo[0] = 2'd1;
        pat[1] = 4'b1011; exo[1] = 2'd2;
        pat[2] = 4'b1001; exo[2] = 2'd2;
        pat[3] = 4'b1001; exo[3] = 2'd2;
        for (int i = 0; i < 4; i++) begin
            req_n = pat[i];
            exp_q.push_back(exo[i]);
            tick();
            e = exp_q.pop_front();
            checks++; if (grnt !== onehot_low(e)) $display("FAIL reassert_grant i=%0d got=%b exp=%b", i, grnt, onehot_low(e)); else passed++;
        end
    endtask

    task automatic test_timeout();
        req_n = 4'hF;
        reset_pulse();
        req_n = 4'b1100;
`ifdef BUS_ARB_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (m1_grnt_ !== 1'b0 && n < 400) begin
                tick();
                n++;
            end
            checks++; if (n < 250 || n > 260) $display("FAIL timeout_cycles got=%0d exp=255..256", n); else passed++;
            checks++; if (arb_timeout !== 1'b1) $display("FAIL timeout_flag got=%b exp=1", arb_timeout); else passed++;
            req_n = 4'hF;
            for (int t = 0; t < 10; t++) tick();
            checks++; if (arb_timeout !== 1'b1) $display("FAIL timeout_sticky got=%b exp=1", arb_timeout); else passed++;
            reset_pulse();
            checks++; if (arb_timeout !== 1'b0) $display("FAIL timeout_clear got=%b exp=0", arb_timeout); else passed++;
        end
`else
        begin
            logic [1:0] e;
            for (int t = 0; t < 1000; t++) begin
                exp_q.push_back(2'd0);
                tick();
                e = exp_q.pop_front();
                checks++; if (grnt !== onehot_low(e)) $display("FAIL hold_forever t=%0d got=%b exp=%b", t, grnt, onehot_low(e)); else passed++;
            end
            checks++; if (arb_timeout !== 1'b0) $display("FAIL no_timeout_flag got=%b exp=0", arb_timeout); else passed++;
        end
`endif
    endtask

    initial begin
        addr[0] = 30'h0000_0100; addr[1] = 30'h2000_0200; addr[2] = 30'h1000_0004; addr[3] = 30'h0300_0300;
        wd[0] = 32'hA0A0_0000; wd[1] = 32'hB1B1_1111; wd[2] = 32'hC2C2_2222; wd[3] = 32'hD3D3_3333;
        rw = 4'b0101;
        test_reset();
        test_handover();
        test_round_robin();
        test_skip();
        test_strobe_block();
        test_parking();
        test_reassert();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
